// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receiver (and the future transmitter).
//   rx_state_t  : receiver FSM states
//   OVERSAMPLE  : baud ticks per serial bit
//   MID_SAMPLE  : tick count at which the start bit is re-checked
//   LAST_SAMPLE : tick count at which data/stop bits are sampled
//   DATA_BITS   : data bits per frame (8N1)
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int         OVERSAMPLE  = 16;
   localparam logic [3:0] MID_SAMPLE  = 4'd7;
   localparam logic [3:0] LAST_SAMPLE = 4'd15;
   localparam logic [3:0] DATA_BITS   = 4'd8;
   localparam logic [3:0] LAST_BIT    = DATA_BITS - 4'd1;

   // Clocks per oversample tick for a given system clock and bit rate.
   function automatic int calc_divisor(input int clk_freq, input int baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// -----------------------------------------------------------------------------
// baud_rate_generator
// Free-running divider producing a one-clock tick every DIVISOR clocks.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  synchronous active-low reset (counter cleared, tick low)
//   tick  out 1-clk pulse while the counter sits at DIVISOR-1
// -----------------------------------------------------------------------------
module baud_rate_generator #(
   parameter int DIVISOR = 162
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (count_reg == LAST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Decoded from the counter so the pulse is exactly one clock wide and
   // low while reset holds the counter at zero.
   assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, 16x oversampling, with its own tick generator.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   baud_rate  out  oversample tick (1-clk pulse every DIVISOR clocks)
//   d_out      out  last received byte, updated only with rx_done
//   rx_done    out  1-clk strobe, d_out valid
//   frame_err  out  1-clk strobe alongside rx_done when the stop bit was 0
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 19200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       baud_rate,
   output logic [7:0] d_out,
   output logic       rx_done,
   output logic       frame_err
);

   localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);

   logic tick;

   baud_rate_generator #(
      .DIVISOR (DIVISOR)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Two-flop synchroniser; preset to the idle level so reset never looks
   // like a start bit.
   logic [1:0] sync_reg;
   logic       rx_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx};
      end
   end

   assign rx_s = sync_reg[1];

   rx_state_t  state_reg,     state_next;
   logic [3:0] cnt_reg,       cnt_next;
   logic [3:0] bitn_reg,      bitn_next;
   logic [7:0] sr_reg,        sr_next;
   logic [7:0] d_out_reg,     d_out_next;
   logic       rx_done_reg,   rx_done_next;
   logic       frame_err_reg, frame_err_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bitn_reg      <= '0;
         sr_reg        <= '0;
         d_out_reg     <= '0;
         rx_done_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bitn_reg      <= bitn_next;
         sr_reg        <= sr_next;
         d_out_reg     <= d_out_next;
         rx_done_reg   <= rx_done_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bitn_next      = bitn_reg;
      sr_next        = sr_reg;
      d_out_next     = d_out_reg;
      rx_done_next   = 1'b0;
      frame_err_next = 1'b0;

      // The FSM only advances on oversample ticks.
      if (tick) begin
         case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_next = START;
                  cnt_next   = '0;
               end
            end

            START: begin
               // Re-check the line mid start bit to reject short glitches.
               if (cnt_reg == MID_SAMPLE) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     cnt_next   = '0;
                     bitn_next  = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end

            DATA: begin
               // Sampling is anchored to mid start bit, so every sample
               // after 16 ticks lands in the middle of the next bit.
               if (cnt_reg == LAST_SAMPLE) begin
                  sr_next   = {rx_s, sr_reg[7:1]};
                  cnt_next  = '0;
                  bitn_next = bitn_reg + 4'd1;
                  if (bitn_reg == LAST_BIT) begin
                     state_next = STOP;
                  end
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end

            STOP: begin
               if (cnt_reg == LAST_SAMPLE) begin
                  d_out_next     = sr_reg;
                  rx_done_next   = 1'b1;
                  frame_err_next = ~rx_s;
                  cnt_next       = '0;
                  // A low stop bit means a break or framing fault; wait for
                  // the line to return high before hunting for a start bit.
                  state_next     = rx_s ? IDLE : BREAK;
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end

            BREAK: begin
               if (rx_s) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign baud_rate = tick;
   assign d_out     = d_out_reg;
   assign rx_done   = rx_done_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. The main instance uses a short tick period
// (4 clocks) so many frames fit in a short run; a second instance with the
// default parameters checks the 162-clock tick period.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int TB_CLK_FREQ = 640_000;
   localparam int TB_BAUD     = 10_000;   // 640000 / (10000*16) = 4 clk/tick
   localparam int DEF_DIVISOR = 162;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       baud_rate;
   logic [7:0] d_out;
   logic       rx_done;
   logic       frame_err;

   logic       rst_n_def;
   logic       rx_def;
   logic       baud_rate_def;
   logic [7:0] d_out_def;
   logic       rx_done_def;
   logic       frame_err_def;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ  (TB_CLK_FREQ),
      .BAUD_RATE (TB_BAUD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .baud_rate (baud_rate),
      .d_out     (d_out),
      .rx_done   (rx_done),
      .frame_err (frame_err)
   );

   uart_rx dut_def (
      .clk       (clk),
      .rst_n     (rst_n_def),
      .rx        (rx_def),
      .baud_rate (baud_rate_def),
      .d_out     (d_out_def),
      .rx_done   (rx_done_def),
      .frame_err (frame_err_def)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       ferr;
      logic [7:0] data;
   } ev_t;

   ev_t mon_q[$];
   ev_t exp_q[$];
   int  stray_ferr = 0;

   // Observe every clock: record each strobe, and count frame_err pulses
   // that arrive without rx_done.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rx_done === 1'b1) begin
            mon_q.push_back({frame_err, d_out});
         end else if (frame_err !== 1'b0) begin
            stray_ferr++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance n oversample ticks; returns just after the tick edge.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         @(negedge clk);
         while (baud_rate !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (baud_rate !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: got no baud_rate within 50 clk, expected a pulse");
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic val, input int ticks);
      rx = val;
      wait_ticks(ticks);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_ticks);
      drive_bit(1'b0, 16);
      for (int b = 0; b < 8; b++) begin
         drive_bit(data[b], 16);
      end
      drive_bit(stop, stop_ticks);
      rx = 1'b1;
   endtask

   task automatic expect_ev(input logic [7:0] data, input logic ferr);
      exp_q.push_back({ferr, data});
   endtask

   // Compare recorded strobes against the expected list, then clear both.
   task automatic verify(input string name);
      check($sformatf("%s.count", name), mon_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         $display("%s frame %0d: d_out=0x%02h frame_err=%0b (want 0x%02h/%0b)",
                  name, i, mon_q[i].data, mon_q[i].ferr, exp_q[i].data, exp_q[i].ferr);
         check($sformatf("%s.data[%0d]", name, i), mon_q[i].data, exp_q[i].data);
         check($sformatf("%s.ferr[%0d]", name, i), mon_q[i].ferr, exp_q[i].ferr);
      end
      check($sformatf("%s.stray_ferr", name), stray_ferr, 0);
      mon_q.delete();
      exp_q.delete();
      stray_ferr = 0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         stop_ticks;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int         cnt;
      logic [7:0] last_data;

      vecs[0] = '{data: 8'h99, stop: 1'b1, stop_ticks: 16, exp_data: 8'h99, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h5A, stop: 1'b1, stop_ticks: 16, exp_data: 8'h5A, exp_ferr: 1'b0};
      // Low stop bit held for three bit times: one strobe, then silence.
      vecs[2] = '{data: 8'h66, stop: 1'b0, stop_ticks: 48, exp_data: 8'h66, exp_ferr: 1'b1};
      vecs[3] = '{data: 8'hFF, stop: 1'b1, stop_ticks: 16, exp_data: 8'hFF, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h00, stop: 1'b1, stop_ticks: 16, exp_data: 8'h00, exp_ferr: 1'b0};

      // ---------------- reset state ----------------
      rst_n     = 1'b0;
      rst_n_def = 1'b0;
      rx        = 1'b1;
      rx_def    = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset.baud_rate", baud_rate, 1'b0);
      check("reset.d_out", d_out, 8'h00);
      check("reset.rx_done", rx_done, 1'b0);
      check("reset.frame_err", frame_err, 1'b0);
      check("reset.baud_rate_def", baud_rate_def, 1'b0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rst_n_def = 1'b1;

      // ---------------- tick period at default parameters ----------------
      cnt = 0;
      while (baud_rate_def !== 1'b1 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("tick.first_pulse", baud_rate_def, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("tick.width", baud_rate_def, 1'b0);
         cnt = 1;
         while (cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (baud_rate_def === 1'b1) break;
         end
         check("tick.period", cnt, DEF_DIVISOR);
      end

      // ---------------- table-driven frames ----------------
      wait_ticks(4);
      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].stop_ticks);
         wait_ticks(4);
         expect_ev(vecs[v].exp_data, vecs[v].exp_ferr);
         verify($sformatf("vec%0d", v));
         check($sformatf("vec%0d.d_out_hold", v), d_out, vecs[v].exp_data);
      end

      // ---------------- back-to-back, one stop bit ----------------
      send_frame(8'h01, 1'b1, 16);
      send_frame(8'h80, 1'b1, 16);
      wait_ticks(4);
      expect_ev(8'h01, 1'b0);
      expect_ev(8'h80, 1'b0);
      verify("b2b");
      check("b2b.d_out_hold", d_out, 8'h80);

      // ---------------- 4-tick glitch is rejected ----------------
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 24);
      verify("glitch");
      check("glitch.d_out_unchanged", d_out, 8'h80);

      // ---------------- reset during data bit 3 ----------------
      drive_bit(1'b0, 16);
      for (int b = 0; b < 3; b++) begin
         drive_bit(b[0], 16);
      end
      drive_bit(1'b1, 8);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midreset.d_out", d_out, 8'h00);
      check("midreset.rx_done", rx_done, 1'b0);
      rx = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ticks(40);
      verify("midreset.none");
      check("midreset.d_out_after", d_out, 8'h00);
      send_frame(8'hA5, 1'b1, 16);
      wait_ticks(4);
      expect_ev(8'hA5, 1'b0);
      verify("after_reset");

      // ---------------- randomized frames vs. reference model ----------------
      last_data = 8'hA5;
      for (int f = 0; f < 20; f++) begin
         logic [7:0] data;
         logic       stop;
         int         gap;
         data = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         // A low stop bit needs the line high for at least one tick to
         // leave the break condition before the next start bit.
         gap  = stop ? $urandom_range(0, 6) : $urandom_range(1, 6);
         send_frame(data, stop, 16);
         if (gap > 0) drive_bit(1'b1, gap);
         expect_ev(data, ~stop);
         last_data = data;
      end
      wait_ticks(4);
      verify("random");
      check("random.d_out_hold", d_out, last_data);

      // Idle default-parameter instance never strobes.
      check("def.rx_done", rx_done_def, 1'b0);
      check("def.frame_err", frame_err_def, 1'b0);
      check("def.d_out", d_out_def, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test by 5 ms, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
